// File: rtl/mod_mult_interleaved_pkg.sv
// Shared elliptic-curve types and secp256k1 constants used by the field-arithmetic stages.
// Also defines the state encoding of the interleaved modular multiplier.
package elliptic_curve_structs;

  localparam int EC_WIDTH = 256;

  typedef logic [EC_WIDTH-1:0] ec_word_t;

  typedef struct packed {
    ec_word_t x;
    ec_word_t y;
  } curve_point_t;

  typedef struct packed {
    ec_word_t p;
    ec_word_t n;
    ec_word_t a;
    ec_word_t b;
  } curve_params_t;

  // secp256k1 domain parameters: field prime p, group order n, curve y^2 = x^3 + 7.
  localparam curve_params_t params = '{
    p: 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F,
    n: 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141,
    a: 256'h0,
    b: 256'h7
  };

  localparam curve_point_t base_point = '{
    x: 256'h79BE667E_F9DCBBAC_55A06295_CE870B07_029BFCDB_2DCE28D9_59F2815B_16F81798,
    y: 256'h483ADA77_26A3C465_5DA4FBFC_0E1108A8_FD17B448_A6855419_9C47D08F_FB10D4B8
  };

  typedef enum logic [1:0] {
    MM_IDLE,
    MM_RUN,
    MM_DONE
  } mod_mult_state_t;

endpackage

// File: rtl/mod_mult_interleaved_step.sv
// One double-and-add step of the interleaved modular multiplier:
// acc' = (2*acc + bit*a) mod m, using two conditional subtractions.
module mod_mult_step #(
  parameter int WIDTH = 256
) (
  input  logic [WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0] i_a,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_mod,
  output logic [WIDTH-1:0] o_acc
);

  logic [WIDTH:0] w_dbl;
  logic [WIDTH:0] w_dblRed;
  logic [WIDTH:0] w_sum;

  assign w_dbl    = {i_acc, 1'b0};
  assign w_dblRed = (w_dbl >= {1'b0, i_mod}) ? (w_dbl - {1'b0, i_mod}) : w_dbl;
  assign w_sum    = w_dblRed + (i_bit ? {1'b0, i_a} : '0);
  // With acc, a < m the reduced sum fits in WIDTH bits, so the low-bit subtraction is exact.
  assign o_acc    = (w_sum >= {1'b0, i_mod}) ? (w_sum[WIDTH-1:0] - i_mod) : w_sum[WIDTH-1:0];

endmodule

// File: rtl/mod_mult_interleaved.sv
// Sequential modular multiplier: product = (a * b) mod modulus, one multiplier bit per cycle,
// MSB first, with a start/done handshake and a single operation in flight.
module mod_mult_interleaved
  import elliptic_curve_structs::*;
#(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] modulus,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

  mod_mult_state_t r_state;
  mod_mult_state_t w_nextState;
  logic            w_accept;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_mod;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_product;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] w_stepAcc;

  mod_mult_step #(.WIDTH(WIDTH)) u_step (
    .i_acc (r_acc),
    .i_a   (r_a),
    .i_bit (r_b[r_cnt]),
    .i_mod (r_mod),
    .o_acc (w_stepAcc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= MM_IDLE;
    else     r_state <= w_nextState;
  end

  // Start is honoured only when ready, so DONE can hand straight over to the next RUN.
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    unique case (r_state)
      MM_IDLE: begin
        if (start) begin
          w_nextState = MM_RUN;
          w_accept    = 1'b1;
        end
      end
      MM_RUN: begin
        if (r_cnt == '0) w_nextState = MM_DONE;
      end
      MM_DONE: begin
        if (start) begin
          w_nextState = MM_RUN;
          w_accept    = 1'b1;
        end else begin
          w_nextState = MM_IDLE;
        end
      end
      default: w_nextState = MM_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_mod     <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else if (w_accept) begin
      r_a   <= a;
      r_b   <= b;
      r_mod <= modulus;
      r_acc <= '0;
      r_cnt <= CNT_MAX;
    end else if (r_state == MM_RUN) begin
      r_acc <= w_stepAcc;
      if (r_cnt == '0) r_product <= w_stepAcc;
      else             r_cnt     <= r_cnt - CNT_W'(1);
    end
  end

  assign busy    = (r_state == MM_RUN);
  assign done    = (r_state == MM_DONE);
  assign product = r_product;

endmodule

// File: tb/tb_mod_mult_interleaved.sv
// Self-checking bench for mod_mult_interleaved: an 8-bit instance for directed/random vectors
// and handshake corners, and a 256-bit instance exercising the secp256k1 moduli.
module tb_mod_mult_interleaved;
  import elliptic_curve_structs::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, m8 = '0;
  logic       busy8, done8;
  logic [7:0] product8;

  logic         start256 = 1'b0;
  logic [255:0] a256 = '0, b256 = '0, m256 = '0;
  logic         busy256, done256;
  logic [255:0] product256;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mod_mult_interleaved #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .modulus(m8),
    .busy(busy8), .done(done8), .product(product8)
  );

  mod_mult_interleaved #(.WIDTH(256)) dut256 (
    .clk(clk), .rst(rst), .start(start256), .a(a256), .b(b256), .modulus(m256),
    .busy(busy256), .done(done256), .product(product256)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] m;
    logic [7:0] expected;
  } vec_t;

  vec_t vecs[10];

  task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
    end
  endtask

  // Issues one operation on the selected instance and waits (bounded) for done.
  task automatic applyStimulus(input bit big, input logic [255:0] ia, input logic [255:0] ib,
                               input logic [255:0] im, output logic [255:0] prod,
                               output int edges, output int busyCycles);
    int limit;
    limit = big ? 300 : 20;
    @(negedge clk);
    if (big) begin a256 = ia; b256 = ib; m256 = im; start256 = 1'b1; end
    else     begin a8 = ia[7:0]; b8 = ib[7:0]; m8 = im[7:0]; start8 = 1'b1; end
    @(posedge clk); #1;
    start8 = 1'b0; start256 = 1'b0;
    edges = 1; busyCycles = 0;
    while (!(big ? done256 : done8) && edges < limit) begin
      if (big ? busy256 : busy8) busyCycles++;
      @(posedge clk); #1;
      edges++;
    end
    prod = big ? product256 : {248'b0, product8};
    if (!(big ? done256 : done8)) checkOutput("done_timeout", 256'd0, 256'd1);
  endtask

  initial begin
    logic [255:0] prod;
    logic [511:0] wide;
    int edges, busyCycles, doneSeen;
    bit heldOk;

    vecs[0] = '{8'd200, 8'd200, 8'd251, 8'd91};
    vecs[1] = '{8'd3,   8'd5,   8'd251, 8'd15};
    vecs[2] = '{8'd250, 8'd250, 8'd251, 8'd1};
    vecs[3] = '{8'd0,   8'd7,   8'd251, 8'd0};
    vecs[4] = '{8'd123, 8'd0,   8'd251, 8'd0};
    vecs[5] = '{8'd1,   8'd123, 8'd251, 8'd123};
    vecs[6] = '{8'd17,  8'd19,  8'd251, 8'd72};
    vecs[7] = '{8'd12,  8'd11,  8'd13,  8'd2};
    vecs[8] = '{8'd254, 8'd2,   8'd255, 8'd253};
    vecs[9] = '{8'd2,   8'd2,   8'd3,   8'd1};

    #12;
    checkOutput("reset_busy8", {255'b0, busy8}, 256'd0);
    checkOutput("reset_done8", {255'b0, done8}, 256'd0);
    checkOutput("reset_product8", {248'b0, product8}, 256'd0);
    checkOutput("reset_busy256", {255'b0, busy256}, 256'd0);
    checkOutput("reset_product256", product256, 256'd0);
    @(negedge clk); rst = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(1'b0, {248'b0, vecs[i].a}, {248'b0, vecs[i].b}, {248'b0, vecs[i].m},
                    prod, edges, busyCycles);
      checkOutput($sformatf("vec%0d_product", i), prod, {248'b0, vecs[i].expected});
      checkOutput($sformatf("vec%0d_edges", i), 256'(edges), 256'd9);
      checkOutput($sformatf("vec%0d_busy", i), 256'(busyCycles), 256'd8);
    end

    // Back-to-back: start raised during the DONE cycle, old product must hold until the new done.
    applyStimulus(1'b0, 256'd200, 256'd200, 256'd251, prod, edges, busyCycles);
    checkOutput("b2b_first", prod, 256'd91);
    a8 = 8'd3; b8 = 8'd5; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; edges = 1; heldOk = 1'b1;
    while (!done8 && edges < 20) begin
      if (product8 !== 8'd91) heldOk = 1'b0;
      @(posedge clk); #1;
      edges++;
    end
    checkOutput("b2b_edges", 256'(edges), 256'd9);
    checkOutput("b2b_product", {248'b0, product8}, 256'd15);
    checkOutput("b2b_held", {255'b0, heldOk}, 256'd1);

    // Start pulses while busy carry different operands and must be ignored.
    @(negedge clk); a8 = 8'd17; b8 = 8'd19; m8 = 8'd251; start8 = 1'b1;
    @(posedge clk); #1; start8 = 1'b0; edges = 1;
    repeat (3) begin
      @(negedge clk); a8 = 8'd3; b8 = 8'd5; m8 = 8'd13; start8 = 1'b1;
      @(posedge clk); #1; start8 = 1'b0; edges++;
    end
    while (!done8 && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    checkOutput("busy_start_edges", 256'(edges), 256'd9);
    checkOutput("busy_start_product", {248'b0, product8}, 256'd72);

    // Asynchronous reset in the middle of a run.
    @(negedge clk); a8 = 8'd200; b8 = 8'd200; m8 = 8'd251; start8 = 1'b1;
    @(posedge clk); #1; start8 = 1'b0;
    repeat (3) @(posedge clk);
    #3; rst = 1'b1; #1;
    checkOutput("midrst_busy", {255'b0, busy8}, 256'd0);
    checkOutput("midrst_done", {255'b0, done8}, 256'd0);
    checkOutput("midrst_product", {248'b0, product8}, 256'd0);
    @(negedge clk); rst = 1'b0;
    doneSeen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8) doneSeen++;
    end
    checkOutput("midrst_no_done", 256'(doneSeen), 256'd0);
    applyStimulus(1'b0, 256'd200, 256'd200, 256'd251, prod, edges, busyCycles);
    checkOutput("midrst_recover", prod, 256'd91);

    // Full-width secp256k1 operations.
    applyStimulus(1'b1, params.p - 256'd1, params.p - 256'd1, params.p, prod, edges, busyCycles);
    checkOutput("p_minus1_sq", prod, 256'd1);
    checkOutput("p_edges", 256'(edges), 256'd257);
    checkOutput("p_busy", 256'(busyCycles), 256'd256);
    applyStimulus(1'b1, base_point.x, 256'd1, params.p, prod, edges, busyCycles);
    checkOutput("gx_times_1", prod, base_point.x);
    applyStimulus(1'b1, 256'd0, params.n - 256'd1, params.n, prod, edges, busyCycles);
    checkOutput("n_zero_product", prod, 256'd0);
    checkOutput("n_zero_edges", 256'(edges), 256'd257);
    applyStimulus(1'b1, base_point.x, base_point.y, params.p, prod, edges, busyCycles);
    wide = ({256'b0, base_point.x} * {256'b0, base_point.y}) % {256'b0, params.p};
    checkOutput("gx_gy_mod_p", prod, wide[255:0]);

    // Random 8-bit operations against the % reference.
    for (int k = 0; k < 1000; k++) begin
      logic [7:0] rm, ra, rb;
      logic [15:0] ref16;
      rm = 8'($urandom_range(1, 127) * 2 + 1);
      ra = 8'($urandom_range(0, int'(rm) - 1));
      rb = 8'($urandom_range(0, int'(rm) - 1));
      ref16 = ({8'b0, ra} * {8'b0, rb}) % {8'b0, rm};
      applyStimulus(1'b0, {248'b0, ra}, {248'b0, rb}, {248'b0, rm}, prod, edges, busyCycles);
      checkOutput($sformatf("rand%0d_%0d*%0d%%%0d", k, ra, rb, rm), prod, {240'b0, ref16});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
